// File: rtl/part3_mux4x1_pkg.sv
// Shared field positions and reset value for the switch-driven 4:1 mux lab block.
// SW packs the select and four 2-bit words; LED echoes the select and shows the picked word.
package part3_mux4x1_pkg;

   localparam int SW_W   = 10;
   localparam int LED_W  = 10;
   localparam int WORD_W = 2;

   localparam int SEL_HI = 9;
   localparam int SEL_LO = 8;
   localparam int U_LO   = 0;
   localparam int V_LO   = 2;
   localparam int W_LO   = 4;
   localparam int X_LO   = 6;

   localparam logic [LED_W-1:0] LED_RST = 10'b0;

   typedef logic [WORD_W-1:0] word_t;

   // Extracts one 2-bit word starting at bit position lo.
   function automatic word_t sw_word(input logic [SW_W-1:0] sw, input int lo);
      return word_t'(sw >> lo);
   endfunction

endpackage

// File: rtl/part3_mux4x1_if.sv
// Board-pin bundle: switches into the block, LEDs out of it.
interface part3_mux4x1_if;
   import part3_mux4x1_pkg::*;

   logic [SW_W-1:0]  SW;
   logic [LED_W-1:0] LED;

   modport master (output SW, input LED);
   modport slave  (input SW, output LED);

endinterface

// File: rtl/part3_mux4x1_mux4x1_2b.sv
// Purely combinational 2-bit 4:1 mux built from three 2:1 stages.
module mux4x1_2b
   import part3_mux4x1_pkg::*;
(
   input  word_t      u,
   input  word_t      v,
   input  word_t      w,
   input  word_t      x,
   input  logic [1:0] s,
   output word_t      m
);

   // An unknown select resolves to the low input, so the output never goes X from s.
   function automatic word_t mux2(input word_t a, input word_t b, input logic sel);
      if (sel == 1'b1) begin
         return b;
      end else begin
         return a;
      end
   endfunction

   word_t uv;
   word_t wx;

   always_comb begin
      uv = mux2(u, v, s[0]);
      wx = mux2(w, x, s[0]);
      m  = mux2(uv, wx, s[1]);
   end

endmodule

// File: rtl/part3_mux4x1.sv
// Switch-driven 2-bit 4:1 mux with a registered LED output and synchronous reset.
module part3_mux4x1
   import part3_mux4x1_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   part3_mux4x1_if.slave        bus
);

   logic [1:0]       sel;
   word_t            u, v, w, x;
   word_t            m;
   logic [LED_W-1:0] led_d;
   logic [LED_W-1:0] led_q;

   always_comb begin
      sel = bus.SW[SEL_HI:SEL_LO];
      u   = sw_word(bus.SW, U_LO);
      v   = sw_word(bus.SW, V_LO);
      w   = sw_word(bus.SW, W_LO);
      x   = sw_word(bus.SW, X_LO);
   end

   mux4x1_2b u_mux (
      .u (u),
      .v (v),
      .w (w),
      .x (x),
      .s (sel),
      .m (m)
   );

   // Select echo and data word are captured on the same edge so LED is never a mix.
   always_comb begin
      led_d = {sel, 6'b0, m};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q <= LED_RST;
      end else begin
         led_q <= led_d;
      end
   end

   assign bus.LED = led_q;

endmodule

// File: tb/tb_part3_mux4x1.sv
// Scoreboard bench for part3_mux4x1: driver queues expected LED per edge, monitor pops and compares.
module tb_part3_mux4x1;

   logic clk;
   logic reset;

   part3_mux4x1_if bus ();

   part3_mux4x1 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [9:0] exp_q[$];
   logic [9:0] last_exp;
   int         n_checks = 0;
   int         n_fail   = 0;
   int         edge_idx = 0;

   // Independent reference: {S, 6'b0, word[S]}.
   function automatic logic [9:0] model(input logic [9:0] sw);
      logic [1:0] word;
      case (sw[9:8])
         2'b00:   word = sw[1:0];
         2'b01:   word = sw[3:2];
         2'b10:   word = sw[5:4];
         default: word = sw[7:6];
      endcase
      return {sw[9:8], 6'b000000, word};
   endfunction

   // One edge of stimulus: apply inputs, queue the LED value expected after the next edge.
   task automatic drive(input logic [9:0] sw, input logic rst, input logic [9:0] exp);
      bus.SW   = sw;
      reset    = rst;
      exp_q.push_back(exp);
      @(negedge clk);
      last_exp = exp;
   endtask

   // Same as drive, but also confirms LED still holds the old value mid-cycle.
   task automatic drive_mid(input logic [9:0] sw, input logic [9:0] exp, input string name);
      logic [9:0] held;
      held     = last_exp;
      bus.SW   = sw;
      reset    = 1'b0;
      exp_q.push_back(exp);
      #1;
      n_checks++;
      if (bus.LED !== held) begin
         n_fail++;
         $display("FAIL %s hold: LED got %h want %h", name, bus.LED, held);
      end
      @(negedge clk);
      last_exp = exp;
   endtask

   // Monitor: one expected entry per rising edge while the driver is active.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            logic [9:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.LED !== e) begin
               n_fail++;
               $display("FAIL led_edge%0d: LED got %h want %h (SW=%h)", edge_idx, bus.LED, e, bus.SW);
            end
            edge_idx++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      last_exp = 10'h000;
      // Reset held for two edges with all switches high.
      drive(10'h3FF, 1'b1, 10'h000);
      drive(10'h3FF, 1'b1, 10'h000);
      // First edge out of reset loads normally.
      drive(10'h300, 1'b0, 10'h300);

      // Data U=11 V=10 W=01 X=00, stepping only the select.
      drive_mid(10'd27,  10'h003, "sel00");
      drive_mid(10'd283, 10'h102, "sel01");
      drive_mid(10'd539, 10'h201, "sel10");
      drive_mid(10'd795, 10'h300, "sel11");
      // Distinct data patterns, each word unique.
      drive_mid(10'h0E4, 10'h000, "pat_u");
      drive_mid(10'h1E4, 10'h101, "pat_v");
      drive_mid(10'h2E4, 10'h202, "pat_w");
      drive_mid(10'h3E4, 10'h303, "pat_x");

      // Exhaustive sweep with a reset pulse in the middle.
      for (int i = 0; i < 1024; i++) begin
         if (i == 500) begin
            drive(10'(i), 1'b1, 10'h000);
         end else begin
            drive(10'(i), 1'b0, model(10'(i)));
         end
      end

      // Let the monitor drain the queue, bounded.
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
         @(negedge clk);
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
